m_exc_pipe: RTL and testbench
=============================

// Module: m_exc_pipe
// PURPOSE
//  E->M pipeline register for exception state, plus M-stage address-exception detection.
//  Latches PC, BD, the E-stage ExcCode, memory address and memory op each cycle.
//  Produces the final M_ExcCode that CP0 consumes.
//  Remaps an E-stage overflow on a load/store address to AdEL/AdES.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value loaded on reset and on flush (bubble PC)
//  DM_TOP     32'h0000_2FFF  last valid data-memory byte address
// PORTS
//  clk          in   1   pipeline clock, rising edge
//  reset        in   1   synchronous, active-high
//  req          in   1   exception/interrupt taken this cycle; flush to bubble
//  E_PC         in   32  E-stage instruction PC
//  E_BD         in   1   E instruction sits in a branch delay slot
//  E_ExcCode    in   5   E-stage exception code (0 = none, 12 = Ov, others pass through)
//  E_addr       in   32  ALU result (memory address for load/store)
//  E_mem_op     in   3   000 none, 001 LW, 010 LH, 011 LB, 101 SW, 110 SH, 111 SB
//  M_PC         out  32  registered PC
//  M_BD         out  1   registered BD
//  M_addr       out  32  registered address
//  M_mem_op     out  3   registered op; forced to 000 when M_ExcCode!=0 (no DM write/read)
//  M_ExcCode    out  5   final M-stage exception code
//  M_exc        out  1   M_ExcCode != 0
// BEHAVIOUR
//  - Reset, and req on the same edge: all registers load the bubble.
//    Bubble: PC=RESET_PC, BD=0, ExcCode=0, addr=0, op=000. All outputs reflect the bubble next cycle.
//  - reset has priority over req. Otherwise registers load E_* every edge. Latency 1 cycle; no stall input.
//  - M_ExcCode is combinational from registered fields. Priority, highest first:
//    1. reg ExcCode==12 and op is load  -> 4 (AdEL)
//    2. reg ExcCode==12 and op is store -> 5 (AdES)
//    3. reg ExcCode!=0                  -> reg ExcCode (Int/Syscall/RI/AdEL-fetch pass through)
//    4. alignment fault: LW addr[1:0]!=0, LH addr[0]!=0 -> 4; SW/SH equivalently -> 5
//    5. range fault: addr outside [0,DM_TOP] and outside device window 0x7F00..0x7F23 -> 4 load / 5 store
//    6. device rules (macro only, see CONFIGURATION) -> 4 load / 5 store
//    7. otherwise 0
//  - Address 32'hFFFF_FFFC is never in range (no wrap); checks are unsigned compares.
//  - LB/SB never raise alignment faults.
//  - op 000 never raises steps 4-6, whatever the address.
//  - M_mem_op gating is combinational: a faulting access must not reach DM or devices in the same cycle.
// CONFIGURATION
//  M_DEV_CHECK_EN defined: per-device rules are applied.
//   - Valid device ranges: Timer0 0x7F00-0x7F0B, Timer1 0x7F10-0x7F1B, IG 0x7F20-0x7F23.
//     Gaps 0x7F0C-0x7F0F and 0x7F1C-0x7F1F fault.
//   - LH/LB to any timer -> 4; SH/SB to any timer -> 5.
//   - SW to a timer COUNT register (offset 8) -> 5.
//  M_DEV_CHECK_EN undefined: the whole window 0x7F00..0x7F23 is valid for any width. Only alignment and range apply.
// STRUCTURE
//  Shared package: ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12);
//   MEM_OP_* encodings; address-map constants (DM_TOP, TC0/TC1/IG base and limit).
//  Sub-module m_adr_checker: pure combinational (addr, op) -> fault, is_store.
//   It holds the alignment, range and device rules. The top level holds the registers and the priority mux.
// TESTING
//  1. reset=1 for 2 cycles -> M_PC=0x3000, M_BD=0, M_ExcCode=0, M_mem_op=000.
//  2. E_mem_op=LW, E_addr=0x0000_0102, E_ExcCode=0 -> next cycle M_ExcCode=4, M_mem_op=000.
//  3. E_mem_op=SW, E_ExcCode=12, E_addr=0x8000_0000 -> M_ExcCode=5.
//     Same stimulus with E_mem_op=000 -> M_ExcCode=12.
//  4. E_mem_op=SH, E_addr=0x7F04 -> M_ExcCode=5 with M_DEV_CHECK_EN, 0 without.
//     SW to 0x7F08 -> 5 with the macro.
//  5. E_ExcCode=10, E_BD=1, E_PC=0x3010, req=1 on the same edge -> next cycle bubble, M_ExcCode=0.
//     With req=0 -> M_PC=0x3010, M_BD=1, M_ExcCode=10.
//  6. E_mem_op=LB, E_addr=0x2FFF -> 0. LB to 0x3000 -> 4.
//     LW to 0x7F20 -> 0. LW to 0x7F24 -> 4.

Source files
------------

// File: rtl/m_exc_pipe_pkg.sv
// ---------------------------------------------------------------------------
// m_exc_pipe_pkg
//  Shared constants for the E->M exception pipeline:
//   - MIPS ExcCode values consumed by CP0
//   - 3-bit memory-op encodings carried down the pipe
//   - data-memory / device address map
//   - m_regs_t: the E->M register bundle
//   - helpers to classify a memory op as load or store
// ---------------------------------------------------------------------------
package m_exc_pipe_pkg;

    // Exception codes
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Memory op encodings (bit 2 = store)
    localparam logic [2:0] MEM_OP_NONE = 3'b000;
    localparam logic [2:0] MEM_OP_LW   = 3'b001;
    localparam logic [2:0] MEM_OP_LH   = 3'b010;
    localparam logic [2:0] MEM_OP_LB   = 3'b011;
    localparam logic [2:0] MEM_OP_SW   = 3'b101;
    localparam logic [2:0] MEM_OP_SH   = 3'b110;
    localparam logic [2:0] MEM_OP_SB   = 3'b111;

    // Address map
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] DM_TOP_DEF   = 32'h0000_2FFF;
    localparam logic [31:0] DEV_BASE     = 32'h0000_7F00;
    localparam logic [31:0] DEV_LIMIT    = 32'h0000_7F23;
    localparam logic [31:0] TC0_BASE     = 32'h0000_7F00;
    localparam logic [31:0] TC0_LIMIT    = 32'h0000_7F0B;
    localparam logic [31:0] TC1_BASE     = 32'h0000_7F10;
    localparam logic [31:0] TC1_LIMIT    = 32'h0000_7F1B;
    localparam logic [31:0] IG_BASE      = 32'h0000_7F20;
    localparam logic [31:0] IG_LIMIT     = 32'h0000_7F23;

    // E->M register bundle
    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] addr;
        logic [2:0]  op;
    } m_regs_t;

    function automatic logic f_is_load(input logic [2:0] op);
        return (op == MEM_OP_LW) || (op == MEM_OP_LH) || (op == MEM_OP_LB);
    endfunction

    function automatic logic f_is_store(input logic [2:0] op);
        return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
    endfunction

endpackage

// File: rtl/m_exc_pipe_if.sv
// ---------------------------------------------------------------------------
// m_exc_pipe_if
//  E->M exception pipeline bus.
//   master: E-stage side / environment (drives req and E_*, observes M_*)
//   slave : m_exc_pipe (consumes req and E_*, drives M_*)
//  Signals:
//   req        flush to bubble (exception/interrupt taken)
//   E_PC/E_BD/E_ExcCode/E_addr/E_mem_op   E-stage inputs
//   M_PC/M_BD/M_addr/M_mem_op/M_ExcCode/M_exc   M-stage outputs
// ---------------------------------------------------------------------------
interface m_exc_pipe_if;
    logic        req;
    logic [31:0] E_PC;
    logic        E_BD;
    logic [4:0]  E_ExcCode;
    logic [31:0] E_addr;
    logic [2:0]  E_mem_op;

    logic [31:0] M_PC;
    logic        M_BD;
    logic [31:0] M_addr;
    logic [2:0]  M_mem_op;
    logic [4:0]  M_ExcCode;
    logic        M_exc;

    modport master (
        output req, E_PC, E_BD, E_ExcCode, E_addr, E_mem_op,
        input  M_PC, M_BD, M_addr, M_mem_op, M_ExcCode, M_exc
    );

    modport slave (
        input  req, E_PC, E_BD, E_ExcCode, E_addr, E_mem_op,
        output M_PC, M_BD, M_addr, M_mem_op, M_ExcCode, M_exc
    );
endinterface

// File: rtl/m_exc_pipe_adr_checker.sv
// ---------------------------------------------------------------------------
// m_adr_checker
//  Pure combinational data-address checker for the M stage.
//  Ports:
//   addr_i      32  memory address
//   op_i        3   memory op encoding
//   fault_o     1   address exception (alignment, range or device rule)
//   is_store_o  1   op is a store (selects AdES over AdEL)
//  Config: M_DEV_CHECK_EN enables per-device rules (timer/IG ranges,
//  gaps, timer width restrictions, read-only timer COUNT).
// ---------------------------------------------------------------------------
module m_adr_checker
    import m_exc_pipe_pkg::*;
#(
    parameter logic [31:0] DM_TOP = DM_TOP_DEF
) (
    input  logic [31:0] addr_i,
    input  logic [2:0]  op_i,
    output logic        fault_o,
    output logic        is_store_o
);

    logic is_load, is_store, is_word, is_half;
    logic align_fault, range_fault, dev_fault;
    logic in_dm, in_win;

    assign is_load  = f_is_load(op_i);
    assign is_store = f_is_store(op_i);
    assign is_word  = (op_i == MEM_OP_LW) || (op_i == MEM_OP_SW);
    assign is_half  = (op_i == MEM_OP_LH) || (op_i == MEM_OP_SH);

    // Byte accesses are always aligned.
    assign align_fault = (is_word && (addr_i[1:0] != 2'b00)) ||
                         (is_half && addr_i[0]);

    // Unsigned compares: high addresses never wrap back into range.
    assign in_dm  = (addr_i <= DM_TOP);
    assign in_win = (addr_i >= DEV_BASE) && (addr_i <= DEV_LIMIT);
    assign range_fault = !(in_dm || in_win);

`ifdef M_DEV_CHECK_EN
    logic in_tc0, in_tc1, in_ig, in_timer, is_byte;

    assign in_tc0   = (addr_i >= TC0_BASE) && (addr_i <= TC0_LIMIT);
    assign in_tc1   = (addr_i >= TC1_BASE) && (addr_i <= TC1_LIMIT);
    assign in_ig    = (addr_i >= IG_BASE)  && (addr_i <= IG_LIMIT);
    assign in_timer = in_tc0 || in_tc1;
    assign is_byte  = (op_i == MEM_OP_LB) || (op_i == MEM_OP_SB);

    // Timer bases are 16-byte aligned, so COUNT (offset 8) has low nibble 8.
    assign dev_fault = (in_win && !(in_timer || in_ig)) ||
                       (in_timer && (is_half || is_byte)) ||
                       (in_timer && (op_i == MEM_OP_SW) && (addr_i[3:0] == 4'h8));
`else
    assign dev_fault = 1'b0;
`endif

    // op 000 (or any non-access encoding) never faults.
    assign fault_o    = (is_load || is_store) && (align_fault || range_fault || dev_fault);
    assign is_store_o = is_store;

endmodule

// File: rtl/m_exc_pipe.sv
// ---------------------------------------------------------------------------
// m_exc_pipe
//  E->M pipeline register for exception state plus M-stage address-exception
//  detection. Produces the final M_ExcCode consumed by CP0.
//  Ports:
//   clk    pipeline clock, rising edge
//   reset  synchronous, active-high (priority over req)
//   bus    m_exc_pipe_if.slave: req, E_* in; M_* out
//  Parameters: RESET_PC (bubble PC), DM_TOP (last data-memory byte).
//  Config: M_DEV_CHECK_EN enables device rules inside m_adr_checker.
// ---------------------------------------------------------------------------
module m_exc_pipe
    import m_exc_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] DM_TOP   = DM_TOP_DEF
) (
    input  logic         clk,
    input  logic         reset,
    m_exc_pipe_if.slave  bus
);

    m_regs_t regs_q, regs_d;
    logic    adr_fault, adr_is_store;
    logic    op_load, op_store;
    logic [4:0] exc_code;

    localparam m_regs_t BUBBLE = '{pc: RESET_PC, bd: 1'b0, exc: EXC_INT,
                                   addr: 32'h0, op: MEM_OP_NONE};

    always_comb begin
        regs_d = '{pc: bus.E_PC, bd: bus.E_BD, exc: bus.E_ExcCode,
                   addr: bus.E_addr, op: bus.E_mem_op};
    end

    always_ff @(posedge clk) begin
        if (reset || bus.req) regs_q <= BUBBLE;
        else                  regs_q <= regs_d;
    end

    m_adr_checker #(.DM_TOP(DM_TOP)) u_adr_checker (
        .addr_i     (regs_q.addr),
        .op_i       (regs_q.op),
        .fault_o    (adr_fault),
        .is_store_o (adr_is_store)
    );

    assign op_load  = f_is_load(regs_q.op);
    assign op_store = f_is_store(regs_q.op);

    // An overflow on a load/store is an address-calculation overflow, so it
    // is reported as an address error; earlier E-stage codes beat M faults.
    always_comb begin
        exc_code = EXC_INT;
        if (regs_q.exc == EXC_OV && op_load)       exc_code = EXC_ADEL;
        else if (regs_q.exc == EXC_OV && op_store) exc_code = EXC_ADES;
        else if (regs_q.exc != EXC_INT)            exc_code = regs_q.exc;
        else if (adr_fault)                        exc_code = adr_is_store ? EXC_ADES : EXC_ADEL;
    end

    assign bus.M_PC      = regs_q.pc;
    assign bus.M_BD      = regs_q.bd;
    assign bus.M_addr    = regs_q.addr;
    assign bus.M_ExcCode = exc_code;
    assign bus.M_exc     = (exc_code != EXC_INT);
    // Kill the access in the same cycle so a faulting op never reaches DM/devices.
    assign bus.M_mem_op  = (exc_code != EXC_INT) ? MEM_OP_NONE : regs_q.op;

endmodule

// File: tb/tb_m_exc_pipe.sv
// ---------------------------------------------------------------------------
// tb_m_exc_pipe
//  Directed vectors with hand-computed expectations for m_exc_pipe.
//  Device-rule expectations follow M_DEV_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_m_exc_pipe;
    import m_exc_pipe_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    m_exc_pipe_if bus ();

    m_exc_pipe u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Present E-stage inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                        input logic [31:0] addr, input logic [2:0] op, input logic rq);
        bus.E_PC      = pc;
        bus.E_BD      = bd;
        bus.E_ExcCode = exc;
        bus.E_addr    = addr;
        bus.E_mem_op  = op;
        bus.req       = rq;
        @(posedge clk);
        #1;
    endtask

    // Check exception code and gated op together.
    task automatic chk_exc(input string tag, input logic [4:0] exc, input logic [2:0] op);
        chk({tag, ".exc"}, {27'h0, bus.M_ExcCode}, {27'h0, exc});
        chk({tag, ".op"},  {29'h0, bus.M_mem_op},  {29'h0, op});
        chk({tag, ".flag"}, {31'h0, bus.M_exc},    {31'h0, (exc != 5'd0)});
    endtask

    initial begin
        logic [4:0] e_sh, e_sw8, e_sb_gap;
        logic [2:0] o_sh, o_sw8, o_sb_gap;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;

        // 1. reset held for two edges; drive garbage E inputs to prove override
        step(32'h1234_5678, 1'b1, 5'd10, 32'h0000_0003, 3'b001, 1'b0);
        step(32'h1234_5678, 1'b1, 5'd10, 32'h0000_0003, 3'b001, 1'b1);
        chk("rst.pc",   bus.M_PC, 32'h0000_3000);
        chk("rst.bd",   {31'h0, bus.M_BD}, 32'h0);
        chk("rst.addr", bus.M_addr, 32'h0);
        chk_exc("rst", 5'd0, 3'b000);
        reset = 1'b0;

        // 2. LW misaligned in DM
        step(32'h3004, 1'b0, 5'd0, 32'h0000_0102, 3'b001, 1'b0);
        chk_exc("lw_unal", 5'd4, 3'b000);
        chk("lw_unal.addr", bus.M_addr, 32'h0000_0102);

        // 3. Overflow on a store address -> AdES; with no op -> Ov passes through
        step(32'h3008, 1'b0, 5'd12, 32'h8000_0000, 3'b101, 1'b0);
        chk_exc("ov_sw", 5'd5, 3'b000);
        step(32'h3008, 1'b0, 5'd12, 32'h8000_0000, 3'b000, 1'b0);
        chk_exc("ov_none", 5'd12, 3'b000);
        step(32'h300C, 1'b0, 5'd12, 32'h0000_0100, 3'b011, 1'b0);
        chk_exc("ov_lb", 5'd4, 3'b000);

        // 4. Device rules
`ifdef M_DEV_CHECK_EN
        e_sh = 5'd5; o_sh = 3'b000; e_sw8 = 5'd5; o_sw8 = 3'b000; e_sb_gap = 5'd5; o_sb_gap = 3'b000;
`else
        e_sh = 5'd0; o_sh = 3'b110; e_sw8 = 5'd0; o_sw8 = 3'b101; e_sb_gap = 5'd0; o_sb_gap = 3'b111;
`endif
        step(32'h3010, 1'b0, 5'd0, 32'h0000_7F04, 3'b110, 1'b0);
        chk_exc("sh_tc0", e_sh, o_sh);
        step(32'h3014, 1'b0, 5'd0, 32'h0000_7F08, 3'b101, 1'b0);
        chk_exc("sw_count", e_sw8, o_sw8);
        step(32'h3018, 1'b0, 5'd0, 32'h0000_7F0D, 3'b111, 1'b0);
        chk_exc("sb_gap", e_sb_gap, o_sb_gap);
        step(32'h301C, 1'b0, 5'd0, 32'h0000_7F14, 3'b101, 1'b0);
        chk_exc("sw_tc1", 5'd0, 3'b101);

        // 5. req flushes to bubble; without req the instruction passes
        step(32'h3010, 1'b1, 5'd10, 32'h0, 3'b000, 1'b1);
        chk("flush.pc", bus.M_PC, 32'h0000_3000);
        chk("flush.bd", {31'h0, bus.M_BD}, 32'h0);
        chk_exc("flush", 5'd0, 3'b000);
        step(32'h3010, 1'b1, 5'd10, 32'h0, 3'b000, 1'b0);
        chk("ri.pc", bus.M_PC, 32'h0000_3010);
        chk("ri.bd", {31'h0, bus.M_BD}, 32'h1);
        chk_exc("ri", 5'd10, 3'b000);

        // 6. Range boundaries
        step(32'h3020, 1'b0, 5'd0, 32'h0000_2FFF, 3'b011, 1'b0);
        chk_exc("lb_top", 5'd0, 3'b011);
        step(32'h3024, 1'b0, 5'd0, 32'h0000_3000, 3'b011, 1'b0);
        chk_exc("lb_over", 5'd4, 3'b000);
        step(32'h3028, 1'b0, 5'd0, 32'h0000_7F20, 3'b001, 1'b0);
        chk_exc("lw_ig", 5'd0, 3'b001);
        step(32'h302C, 1'b0, 5'd0, 32'h0000_7F24, 3'b001, 1'b0);
        chk_exc("lw_pastwin", 5'd4, 3'b000);
        step(32'h3030, 1'b0, 5'd0, 32'hFFFF_FFFC, 3'b101, 1'b0);
        chk_exc("sw_high", 5'd5, 3'b000);
        step(32'h3034, 1'b0, 5'd0, 32'h0000_7EFF, 3'b111, 1'b0);
        chk_exc("sb_prewin", 5'd5, 3'b000);

        // Alignment and priority corner cases
        step(32'h3038, 1'b0, 5'd0, 32'h0000_0101, 3'b010, 1'b0);
        chk_exc("lh_unal", 5'd4, 3'b000);
        step(32'h303C, 1'b0, 5'd0, 32'h0000_0102, 3'b110, 1'b0);
        chk_exc("sh_al", 5'd0, 3'b110);
        step(32'h3040, 1'b0, 5'd0, 32'hFFFF_FFFF, 3'b000, 1'b0);
        chk_exc("none_bad", 5'd0, 3'b000);
        step(32'h3044, 1'b0, 5'd8, 32'h0000_0103, 3'b001, 1'b0);
        chk_exc("sys_pri", 5'd8, 3'b000);
        step(32'h3048, 1'b0, 5'd0, 32'h0000_0103, 3'b111, 1'b0);
        chk_exc("sb_odd", 5'd0, 3'b111);

        // reset beats req, and both give the bubble
        reset = 1'b1;
        step(32'h3050, 1'b1, 5'd8, 32'h0000_0004, 3'b001, 1'b1);
        chk("rst2.pc", bus.M_PC, 32'h0000_3000);
        chk_exc("rst2", 5'd0, 3'b000);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
